pop_sequencer: RTL and testbench
================================

# pop_sequencer

Run-time-programmable sequencer for the pulsed optical pumping (POP) experiment. It drives the pump laser, microwave (MW) and probe laser gates, and generates an optical-sample window, in the fixed order pump → π/2 → free precession → π/2 → probe. Phase lengths are loaded through a simple register-write port instead of elaboration-time parameters. The block replaces the free-running comparator timer and adds start/stop control, a repeat count and status handshakes.

## Interface
- WIDTH, 16: width of every phase-length register and the internal phase counter.
- REP_W, 16: width of the repeat count.
- clk  in  1  system clock (2.5 MHz PLL output); one clock only.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- stop  in  1  request for a graceful halt at the end of the current sequence; ignored while idle.
- repeat_count  in  REP_W  number of sequences per run, sampled on start; 0 means run until stop.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  3  register address: 0 pump, 1 pi_over_two, 2 free_precession, 3 probe, 4 sample_delay, 5 sample_len, 6 laser_mw_gap; 7 is ignored.
- cfg_data  in  WIDTH  write data.
- pump, mw, probe, sample  out  1  registered experiment gates.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- seq_done  out  1  one-cycle pulse in the last cycle of each sequence (last GAP3 cycle).
- done  out  1  one-cycle pulse in the first IDLE cycle after a run ends.

## Operation
- Reset values of the config registers, in cycles: pump 1000, pi_over_two 1000, free 7500, probe 375, sample_delay 0, sample_len 125, gap 125.
- Reset values of all outputs: 0. State after reset: IDLE.
- Config writes always update the shadow registers.
- The active copy of the config is loaded from the shadow registers on every entry to PUMP. Writes during a sequence therefore take effect from the next sequence.
- State sequence: IDLE → PUMP → GAP1 → MW1 → FREE → MW2 → GAP2 → PROBE → GAP3 → PUMP (or IDLE).
- Each phase lasts exactly its active length, in cycles. A length of 0 is treated as 1; no phase is ever skipped.
- Gate mapping:
  - pump is high in PUMP.
  - mw is high in MW1 and MW2.
  - probe is high in PROBE.
  - sample is high in PROBE cycle k (0-based) when sample_delay ≤ k < sample_delay + sample_len and k < probe.
- The sample comparison uses WIDTH+1 bits, so delay + len cannot wrap.
- sample_len = 0 means no sample pulse.
- The repeat counter is cleared on start and increments at each seq_done.
- At the end of GAP3, the block goes to IDLE if either condition holds; otherwise it goes back to PUMP with no idle gap:
  - a stop is pending;
  - repeat_count ≠ 0 and the counter has reached repeat_count.
- stop is latched in a pending flag, which is cleared on return to IDLE.
- start and stop asserted together in IDLE: start is accepted and stop is ignored.

## Timing
- start sampled high at edge N → busy and pump are high from edge N+1.
- pump stays high for exactly pump cycles.
- Every phase boundary is cycle-exact. Gate outputs are registered together with the state register, so no glitches occur.
- Sequence period = pump + 3·gap + 2·pi_over_two + free + probe. With the reset defaults this is 11250 cycles.
- Phase counter: loaded with (length − 1) on phase entry; the phase ends on the cycle the counter reaches 0.
- seq_done is coincident with the last GAP3 cycle. done is high in the cycle after that, with busy low in the same cycle.
- reset asserted mid-run → on the next edge: all outputs 0, state IDLE, config back to defaults, pending stop cleared; no done pulse.
- A cfg write in the same cycle as PUMP entry is not captured for that sequence. It applies from the next sequence.

## Structure
- Package pop_pkg holds:
  - the state enum;
  - the cfg_addr constants;
  - the default phase lengths as WIDTH-independent localparams.
- Sub-module pop_phase_timer: a loadable WIDTH-bit down counter with load, enable and terminal (zero) flag. One instance is shared by all phases. The PROBE-relative cycle index k for the sample window is derived from a small up counter in the top level.

## Test plan
- Reset defaults with repeat_count=1 → pump 1000, gap 125, mw 1000, gap 7500, mw 1000, gap 125, probe 375 with sample on probe cycles 0–124, gap 125. Then done; busy high for 11250 cycles.
- Program pump=3, pi_over_two=2, free=4, probe=5, delay=1, sample_len=2, gap=1; repeat_count=3 → three back-to-back 19-cycle sequences, three seq_done pulses, done at cycle 58.
- repeat_count=0, stop asserted mid-FREE of sequence 2 → sequence 2 completes fully, then IDLE and done. start while busy is ignored.
- Write pump=6 during PROBE of sequence 1 → sequence 1 is unchanged; sequence 2 pump lasts 6 cycles.
- sample_delay=4, sample_len=10, probe=5 → sample high only in probe cycle 4. A write of 0 to gap produces a 1-cycle gap.
- reset pulsed mid-MW1 → all outputs 0 next cycle, no done, config back to defaults. A following start runs the default timing.

Source files
------------

// File: rtl/pop_pkg.sv
// Shared types and constants for the pulsed-optical-pumping sequencer:
// FSM states, configuration register map and power-on phase lengths.
package pop_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUMP,
    ST_GAP1,
    ST_MW1,
    ST_FREE,
    ST_MW2,
    ST_GAP2,
    ST_PROBE,
    ST_GAP3
  } pop_state_e;

  localparam logic [2:0] ADDR_PUMP    = 3'd0;
  localparam logic [2:0] ADDR_PI2     = 3'd1;
  localparam logic [2:0] ADDR_FREE    = 3'd2;
  localparam logic [2:0] ADDR_PROBE   = 3'd3;
  localparam logic [2:0] ADDR_SDELAY  = 3'd4;
  localparam logic [2:0] ADDR_SLEN    = 3'd5;
  localparam logic [2:0] ADDR_GAP     = 3'd6;
  localparam logic [2:0] ADDR_UNUSED  = 3'd7;

  localparam int unsigned DEF_PUMP    = 1000;
  localparam int unsigned DEF_PI2     = 1000;
  localparam int unsigned DEF_FREE    = 7500;
  localparam int unsigned DEF_PROBE   = 375;
  localparam int unsigned DEF_SDELAY  = 0;
  localparam int unsigned DEF_SLEN    = 125;
  localparam int unsigned DEF_GAP     = 125;

endpackage

// File: rtl/pop_phase_timer.sv
// Loadable down counter shared by every sequencer phase; zero_o marks the
// final cycle of the phase being timed.
module pop_phase_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;

  // Load has priority over counting; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/pop_sequencer.sv
// POP experiment sequencer: pump -> pi/2 -> free precession -> pi/2 -> probe,
// with run-time phase lengths, repeat count, graceful stop and status pulses.
module pop_sequencer
  import pop_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int REP_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [REP_W-1:0] repeat_count,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             pump,
  output logic             mw,
  output logic             probe,
  output logic             sample,
  output logic             busy,
  output logic             seq_done,
  output logic             done
);

  localparam logic [WIDTH-1:0] CFG_DEF [7] = '{
    WIDTH'(DEF_PUMP), WIDTH'(DEF_PI2), WIDTH'(DEF_FREE), WIDTH'(DEF_PROBE),
    WIDTH'(DEF_SDELAY), WIDTH'(DEF_SLEN), WIDTH'(DEF_GAP)
  };

  // A programmed length of zero still occupies one cycle.
  function automatic logic [WIDTH-1:0] len_m1(input logic [WIDTH-1:0] len);
    return (len == '0) ? '0 : len - WIDTH'(1);
  endfunction

  pop_state_e       state_q, nxt_state_s;
  logic [WIDTH-1:0] shadow_q [7];
  logic [WIDTH-1:0] act_q [7];
  logic [WIDTH-1:0] k_q, k_nxt_s;
  logic [REP_W-1:0] rep_q, rep_tgt_q;
  logic             stop_pend_q;
  logic             pump_q, mw_q, probe_q, sample_q, busy_q, seq_done_q, done_q;

  logic [WIDTH-1:0] nxt_len_s, load_val_s, tmr_cnt_s, tmr_nxt_s;
  logic             tmr_zero_s, load_s, start_s, phase_end_s, end_run_s;
  logic             sample_d, seq_done_d, done_d;
  logic [WIDTH:0]   win_end_s;

  pop_phase_timer #(.WIDTH(WIDTH)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_s),
    .en_i       (state_q != ST_IDLE),
    .load_val_i (load_val_s),
    .count_o    (tmr_cnt_s),
    .zero_o     (tmr_zero_s)
  );

  assign start_s     = (state_q == ST_IDLE) && start;
  assign phase_end_s = (state_q != ST_IDLE) && tmr_zero_s;
  assign load_s      = start_s || phase_end_s;
  assign load_val_s  = len_m1(nxt_len_s);
  assign tmr_nxt_s   = load_s ? load_val_s : (tmr_cnt_s - WIDTH'(1));
  // The counter has not yet absorbed the seq_done of the current cycle.
  assign end_run_s   = stop_pend_q || stop ||
                       ((rep_tgt_q != '0) &&
                        (({1'b0, rep_q} + (REP_W+1)'(1)) == {1'b0, rep_tgt_q}));

  // Next phase and the length that the shared timer must load on entry.
  always_comb begin
    nxt_state_s = state_q;
    nxt_len_s   = shadow_q[ADDR_PUMP];
    case (state_q)
      ST_IDLE:  nxt_state_s = start ? ST_PUMP : ST_IDLE;
      ST_PUMP:  begin nxt_state_s = phase_end_s ? ST_GAP1 : ST_PUMP;  nxt_len_s = act_q[ADDR_GAP];   end
      ST_GAP1:  begin nxt_state_s = phase_end_s ? ST_MW1 : ST_GAP1;   nxt_len_s = act_q[ADDR_PI2];   end
      ST_MW1:   begin nxt_state_s = phase_end_s ? ST_FREE : ST_MW1;   nxt_len_s = act_q[ADDR_FREE];  end
      ST_FREE:  begin nxt_state_s = phase_end_s ? ST_MW2 : ST_FREE;   nxt_len_s = act_q[ADDR_PI2];   end
      ST_MW2:   begin nxt_state_s = phase_end_s ? ST_GAP2 : ST_MW2;   nxt_len_s = act_q[ADDR_GAP];   end
      ST_GAP2:  begin nxt_state_s = phase_end_s ? ST_PROBE : ST_GAP2; nxt_len_s = act_q[ADDR_PROBE]; end
      ST_PROBE: begin nxt_state_s = phase_end_s ? ST_GAP3 : ST_PROBE; nxt_len_s = act_q[ADDR_GAP];   end
      ST_GAP3:  nxt_state_s = !phase_end_s ? ST_GAP3 : (end_run_s ? ST_IDLE : ST_PUMP);
      default:  nxt_state_s = ST_IDLE;
    endcase
  end

  // Probe-relative index and the registered-output look-ahead terms.
  always_comb begin
    k_nxt_s    = (state_q == ST_PROBE) ? (k_q + WIDTH'(1)) : '0;
    win_end_s  = {1'b0, act_q[ADDR_SDELAY]} + {1'b0, act_q[ADDR_SLEN]};
    sample_d   = (nxt_state_s == ST_PROBE) &&
                 (k_nxt_s >= act_q[ADDR_SDELAY]) &&
                 ({1'b0, k_nxt_s} < win_end_s) &&
                 (k_nxt_s < act_q[ADDR_PROBE]);
    seq_done_d = (nxt_state_s == ST_GAP3) && (tmr_nxt_s == '0);
    done_d     = (state_q == ST_GAP3) && phase_end_s && end_run_s;
  end

  // State, configuration copies, run bookkeeping and registered gates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shadow_q    <= CFG_DEF;
      act_q       <= CFG_DEF;
      k_q         <= '0;
      rep_q       <= '0;
      rep_tgt_q   <= '0;
      stop_pend_q <= 1'b0;
      pump_q      <= 1'b0;
      mw_q        <= 1'b0;
      probe_q     <= 1'b0;
      sample_q    <= 1'b0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= nxt_state_s;
      k_q     <= k_nxt_s;
      if (cfg_we && (cfg_addr != ADDR_UNUSED)) begin
        shadow_q[cfg_addr] <= cfg_data;
      end
      // The active copy sees the shadow value from before this edge's write.
      if (load_s && (nxt_state_s == ST_PUMP)) begin
        act_q <= shadow_q;
      end
      if (start_s) begin
        rep_q     <= '0;
        rep_tgt_q <= repeat_count;
      end else if (seq_done_q) begin
        rep_q <= rep_q + REP_W'(1);
      end
      if (nxt_state_s == ST_IDLE) begin
        stop_pend_q <= 1'b0;
      end else if (stop && (state_q != ST_IDLE)) begin
        stop_pend_q <= 1'b1;
      end
      pump_q     <= (nxt_state_s == ST_PUMP);
      mw_q       <= (nxt_state_s == ST_MW1) || (nxt_state_s == ST_MW2);
      probe_q    <= (nxt_state_s == ST_PROBE);
      sample_q   <= sample_d;
      busy_q     <= (nxt_state_s != ST_IDLE);
      seq_done_q <= seq_done_d;
      done_q     <= done_d;
    end
  end

  assign pump     = pump_q;
  assign mw       = mw_q;
  assign probe    = probe_q;
  assign sample   = sample_q;
  assign busy     = busy_q;
  assign seq_done = seq_done_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pop_sequencer.sv
// Scoreboard bench for pop_sequencer: a sequence-list reference model pushes the
// expected output vector for every cycle, a monitor pops and compares on negedge.
module tb_pop_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] repeat_count = 16'd0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [15:0] cfg_data = 16'd0;
  logic        pump, mw, probe, sample, busy, seq_done, done;

  int n_checks = 0;
  int n_pass = 0;

  pop_sequencer dut (
    .clk (clk), .reset (reset), .start (start), .stop (stop),
    .repeat_count (repeat_count), .cfg_we (cfg_we), .cfg_addr (cfg_addr),
    .cfg_data (cfg_data), .pump (pump), .mw (mw), .probe (probe),
    .sample (sample), .busy (busy), .seq_done (seq_done), .done (done)
  );

  always #5 clk = ~clk;

  // Vector layout: {busy, pump, mw, probe, sample, seq_done, done}
  localparam int          PH_IDX [8] = '{0, 6, 1, 2, 1, 6, 3, 6};
  localparam logic [6:0]  PH_VEC [8] = '{7'b1100000, 7'b1000000, 7'b1010000, 7'b1000000,
                                         7'b1010000, 7'b1000000, 7'b1001000, 7'b1000000};
  localparam int          CFG_DEFAULTS [7] = '{1000, 1000, 7500, 375, 0, 125, 125};

  logic [6:0] exp_q [$];
  logic [6:0] m_seq [$];
  int         m_cfg [7];
  bit         m_run;
  bit         m_pend;
  int         m_tgt;
  int         m_cnt;

  // Expand one whole sequence into per-cycle output vectors from the config.
  function automatic void build_seq();
    logic [6:0] v;
    int n;
    for (int p = 0; p < 8; p++) begin
      n = (m_cfg[PH_IDX[p]] == 0) ? 1 : m_cfg[PH_IDX[p]];
      for (int k = 0; k < n; k++) begin
        v = PH_VEC[p];
        if (p == 6 && k >= m_cfg[4] && k < m_cfg[4] + m_cfg[5] && k < m_cfg[3]) v[2] = 1'b1;
        m_seq.push_back(v);
      end
    end
    v = m_seq.pop_back();
    v[1] = 1'b1;
    m_seq.push_back(v);
  endfunction

  // Reference model: decides what the next cycle must show after each edge.
  initial begin
    logic [6:0] vec;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_cfg = CFG_DEFAULTS;
        m_run = 1'b0;
        m_pend = 1'b0;
        m_seq.delete();
        exp_q.push_back(7'b0);
      end else begin
        vec = 7'b0;
        if (!m_run) begin
          if (start) begin
            m_run = 1'b1; m_pend = 1'b0; m_tgt = int'(repeat_count); m_cnt = 0;
            build_seq();
            vec = m_seq.pop_front();
          end
        end else begin
          if (stop) m_pend = 1'b1;
          if (m_seq.size() == 0) begin
            m_cnt++;
            if (m_pend || (m_tgt != 0 && m_cnt == m_tgt)) begin
              vec = 7'b0000001;
              m_run = 1'b0;
              m_pend = 1'b0;
            end else begin
              build_seq();
              vec = m_seq.pop_front();
            end
          end else begin
            vec = m_seq.pop_front();
          end
        end
        if (cfg_we && cfg_addr != 3'd7) m_cfg[cfg_addr] = int'(cfg_data);
        exp_q.push_back(vec);
      end
    end
  end

  // Monitor: compare every presented cycle against the scoreboard head.
  initial begin
    logic [6:0] got, want;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got = {busy, pump, mw, probe, sample, seq_done, done};
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL outputs t=%0t got {busy,pump,mw,probe,sample,seq_done,done}=%b expected %b",
                      $time, got, want);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input int a, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = 16'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Start a run, inject per-cycle events, then wait (bounded) for busy to fall.
  task automatic run(input int rc, input int stop_at, input int again_at, input int wr_at,
                     input int wr_a, input int wr_d, input bit with_stop, input int budget);
    bit finished = 1'b0;
    @(negedge clk);
    start = 1'b1; repeat_count = 16'(rc); stop = with_stop;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin finished = 1'b1; break; end
      start = (i == again_at);
      stop = (i == stop_at);
      cfg_we = (i == wr_at); cfg_addr = 3'(wr_a); cfg_data = 16'(wr_d);
    end
    start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    n_checks++;
    if (finished) n_pass++;
    else $display("FAIL run_timeout busy still %b after %0d cycles, expected 0", busy, budget);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int rc, sa;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run(1, -1, -1, -1, 0, 0, 1'b0, 12000);           // defaults, one sequence

    wr(0, 3); wr(1, 2); wr(2, 4); wr(3, 5); wr(4, 1); wr(5, 2); wr(6, 1);
    run(3, -1, -1, -1, 0, 0, 1'b0, 200);             // three 19-cycle sequences
    run(0, 26, 5, -1, 0, 0, 1'b0, 200);              // stop mid-FREE of seq 2, start while busy
    run(2, -1, -1, 14, 0, 6, 1'b0, 200);             // pump write during seq 1 PROBE
    wr(0, 3);
    wr(4, 4); wr(5, 10); wr(6, 0);
    run(1, -1, -1, -1, 0, 0, 1'b1, 200);             // late window, zero gap, start+stop
    @(negedge clk); stop = 1'b1; @(negedge clk); stop = 1'b0;
    run(2, -1, -1, -1, 0, 0, 1'b0, 200);             // idle stop must be ignored

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 8; a++) wr(a, $urandom_range(0, 5));
      rc = $urandom_range(0, 3);
      sa = (rc == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(0, 60) : -1;
      run(rc, sa, $urandom_range(0, 40), $urandom_range(0, 40),
          $urandom_range(0, 7), $urandom_range(0, 5), 1'($urandom_range(0, 1)), 400);
    end

    wr(0, 3); wr(1, 2); wr(6, 1);
    @(negedge clk); start = 1'b1; repeat_count = 16'd0;
    @(negedge clk); start = 1'b0;                     // cycle 0 of PUMP
    repeat (4) @(negedge clk);                        // cycle 4: inside MW1
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    run(1, -1, -1, -1, 0, 0, 1'b0, 12000);           // defaults restored by reset

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
